clk_div_monitor: RTL and testbench
==================================

# clk_div_monitor

Checks a divided clock as a sampled signal in the `clk` domain. It measures the period and high time of `clkin` in `clk` cycles and compares each measurement against the expected divide ratio `DIV`. It reports lock, error pulses and a saturating error count. It sits downstream of the clock dividers as their consumer-side checker, for bring-up and for run-time health monitoring.

## Interface
- `DIV`, 5: expected divide ratio; legal range 2..63.
- `CNT_W`, 8: width of the measurement and error counters; must satisfy 2*DIV < 2^CNT_W.
- `LOCK_CNT`, 4: number of consecutive good measurements required to assert `locked`; range 1..15.

Ports:
- `clk`  input  1  system clock; all logic on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `clkin`  input  1  divided clock under test, treated as data.
- `period`  output  CNT_W  last measured period in clk cycles.
- `high_time`  output  CNT_W  last measured high time in clk cycles.
- `meas_valid`  output  1  one-cycle pulse; `period` and `high_time` were updated this cycle.
- `locked`  output  1  LOCK_CNT consecutive good measurements, no error since.
- `err`  output  1  one-cycle pulse on a bad measurement or a timeout.
- `err_cnt`  output  CNT_W  count of `err` pulses, saturating at all-ones.

## Operation
- **Synchronizer:** `clkin` passes through two flops, s1 then s2. A third flop s3 holds the previous s2. `rise` = s2 & ~s3.
- **States:**
  - IDLE: wait for the first `rise`; no measurement.
  - MEASURE: counting.
- **IDLE to MEASURE on `rise`:** cnt <= 1, hcnt <= 1; no `meas_valid`.
- **MEASURE, no `rise`:** cnt <= cnt+1; hcnt <= hcnt + s2.
- **MEASURE on `rise`:**
  - Update outputs: `period` <= cnt, `high_time` <= hcnt, `meas_valid` <= 1.
  - Restart counters: cnt <= 1, hcnt <= 1.
- **Good measurement:** cnt == DIV, and hcnt == floor(DIV/2) or hcnt == ceil(DIV/2). For DIV=5 the accepted high times are 2 or 3.
- **Good measurement effect:** good_cnt increments, saturating at LOCK_CNT. `locked` <= 1 once the incremented good_cnt equals LOCK_CNT.
- **Bad measurement effect:**
  - `err` pulses.
  - `err_cnt` increments, saturating.
  - good_cnt <= 0 and `locked` <= 0.
- **Timeout:** in MEASURE, cnt == 2*DIV with no `rise` in that cycle.
  - Same effect as a bad measurement, but `period`/`high_time` are not updated and `meas_valid` stays 0.
  - State returns to IDLE, so a stuck `clkin` produces exactly one `err`.
- **Simultaneous events:** `rise` has priority over timeout. A `rise` with cnt == 2*DIV is a normal, bad measurement.
- **Arithmetic:** cnt never exceeds 2*DIV. hcnt ≤ cnt always; no wrap is possible.

## Timing
- **Reset values:** `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `err`=0, `err_cnt`=0.
- **Internal reset state:** state IDLE; s1/s2/s3, cnt, hcnt, good_cnt all 0.
- **Reset mid-operation:** `rst` high at any posedge restores every register to its reset value on that edge. After release, the first `rise` only re-arms.
- **Edge-to-`rise` latency:** if `clkin` is first sampled high at posedge k, `rise` is true during the cycle after posedge k+1.
- **Output latency:** outputs, `meas_valid`, `err` and `locked` change at posedge k+2. Total latency from first high sample to `meas_valid` is 3 posedges.
- **Pulse width:** `meas_valid` and `err` are high for exactly one cycle.
- **Same-cycle visibility:** `err` for a bad measurement coincides with that measurement's `meas_valid`. `locked` rises or falls in the same cycle as the deciding `meas_valid`/`err`.
- **Timeout timing:** `err` appears one posedge after the cycle in which cnt == 2*DIV.
- **Back-to-back measurements:** one every DIV cycles with no dead cycles.

## Test plan
- **Ideal divide-by-5** (samples 1,1,1,0,0 repeating), DIV=5, LOCK_CNT=4 -> every 5 cycles `meas_valid` with `period`=5, `high_time`=3. `locked`=1 with the 4th `meas_valid`; `err` never asserted.
- **Divide-by-4** (1,1,0,0) after lock -> first measurement gives `period`=4, `err`=1, `locked`=0, `err_cnt`=1. `err_cnt` then increments on every subsequent measurement.
- **Duty error** (1,0,0,0,0) from reset -> `period`=5, `high_time`=1, `err` on each measurement, `locked` stays 0.
- **Stuck low after lock** -> exactly one `err` 10 cycles after the last `rise`, `locked`=0. No further `err`. Restoring the ideal pattern gives re-arm, then `locked` after 4 good measurements.
- **`rst` mid-measurement while locked** -> all outputs 0 on the next posedge. The first `rise` after release produces no `meas_valid`; the second produces `period`=5.
- **Error saturation,** CNT_W=4, continuous divide-by-4 -> `err_cnt` reaches 15 and holds; `err` keeps pulsing.

Source files
------------

// File: rtl/clk_div_monitor_if.sv
// Signal bundle between the divided-clock source side and the clk_div_monitor checker.
interface clk_div_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             clkin;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    // master: the checker, which observes clkin and produces the measurements
    modport master (
        input  clkin,
        output period, high_time, meas_valid, locked, err, err_cnt
    );

    modport slave (
        output clkin,
        input  period, high_time, meas_valid, locked, err, err_cnt
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled in the clk domain and
// checks them against DIV, reporting lock, error pulses and a saturating error count.
module clk_div_monitor #(
    parameter int unsigned DIV      = 5,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    clk_div_monitor_if.master     mon_io
);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    localparam logic [CNT_W-1:0] One    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DivC   = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] TwoDiv = CNT_W'(2 * DIV);
    localparam logic [CNT_W-1:0] HiLo   = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] HiHi   = CNT_W'((DIV + 1) / 2);
    localparam logic [3:0]       LockC  = 4'(LOCK_CNT);
    localparam logic [3:0]       LockM1 = 4'(LOCK_CNT - 1);

    state_e           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, hcnt_q;
    logic [CNT_W-1:0] period_q, high_q, err_cnt_q;
    logic [3:0]       good_q;
    logic             mv_q, err_q, locked_q;

    logic rise, good_meas, timeout, bad;

    always_comb begin
        rise      = s2_q & ~s3_q;
        good_meas = (cnt_q == DivC) && ((hcnt_q == HiLo) || (hcnt_q == HiHi));
        // rise wins over timeout when both land on cnt == 2*DIV
        timeout   = (state_q == StMeasure) && !rise && (cnt_q == TwoDiv);
        bad       = ((state_q == StMeasure) && rise && !good_meas) || timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            err_cnt_q <= '0;
            good_q    <= '0;
            mv_q      <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            s1_q  <= mon_io.clkin;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            mv_q  <= 1'b0;
            err_q <= 1'b0;

            if (bad) begin
                err_q    <= 1'b1;
                good_q   <= '0;
                locked_q <= 1'b0;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + One;
            end

            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q <= StMeasure;
                        cnt_q   <= One;
                        hcnt_q  <= One;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        period_q <= cnt_q;
                        high_q   <= hcnt_q;
                        mv_q     <= 1'b1;
                        cnt_q    <= One;
                        hcnt_q   <= One;
                        if (good_meas) begin
                            if (good_q < LockC) good_q <= good_q + 4'd1;
                            if (good_q >= LockM1) locked_q <= 1'b1;
                        end
                    end else if (timeout) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        hcnt_q  <= '0;
                    end else begin
                        cnt_q  <= cnt_q + One;
                        hcnt_q <= hcnt_q + CNT_W'(s2_q);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mon_io.period     = period_q;
    assign mon_io.high_time  = high_q;
    assign mon_io.meas_valid = mv_q;
    assign mon_io.err        = err_q;
    assign mon_io.locked     = locked_q;
    assign mon_io.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: a rise-timestamp model queues expected events,
// a negedge monitor pops and compares them whenever the DUT pulses meas_valid or err.
module tb_clk_div_monitor;

    localparam int unsigned DIV   = 5;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LOCK  = 4;
    localparam int          ECMAX = (1 << CNT_W) - 1;

    typedef struct {
        int t;
        bit mv;
        bit er;
        int per;
        int hi;
        bit lk;
        int ec;
    } ev_t;

    logic clk;
    logic rst;
    logic rst_seen;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    ev_t  exp_q[$];

    // reference model state: expressed in sample indices and rise timestamps
    bit m_armed, m_prev, m_lck;
    int m_last, m_hi, m_good, m_ec;

    clk_div_monitor_if #(.CNT_W(CNT_W)) mon ();

    clk_div_monitor #(
        .DIV      (DIV),
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mon_io (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_armed = 0; m_prev = 0; m_lck = 0;
        m_last = 0; m_hi = 0; m_good = 0; m_ec = 0;
    endfunction

    function automatic void model_bad();
        m_good = 0;
        m_lck  = 0;
        if (m_ec < ECMAX) m_ec++;
    endfunction

    function automatic void model_push(int t, bit mv, bit er, int p, int h);
        ev_t e;
        e.t = t; e.mv = mv; e.er = er; e.per = p; e.hi = h; e.lk = m_lck; e.ec = m_ec;
        exp_q.push_back(e);
    endfunction

    // j is the posedge index at which sample v is captured; outputs land at posedge j+2
    function automatic void model_step(int j, bit v);
        bit r;
        bit ok;
        int p;
        r      = v && !m_prev;
        m_prev = v;
        if (r) begin
            if (m_armed) begin
                p  = j - m_last;
                ok = (p == DIV) && (m_hi == DIV / 2 || m_hi == (DIV + 1) / 2);
                if (ok) begin
                    if (m_good < LOCK) m_good++;
                    if (m_good == LOCK) m_lck = 1;
                end else begin
                    model_bad();
                end
                model_push(j + 2, 1, !ok, p, m_hi);
            end
            m_armed = 1;
            m_last  = j;
            m_hi    = 1;
        end else if (m_armed) begin
            if (j - m_last == 2 * DIV) begin
                model_bad();
                model_push(j + 2, 0, 1, 0, 0);
                m_armed = 0;
            end else begin
                m_hi += int'(v);
            end
        end
    endfunction

    task automatic drive(bit v);
        @(negedge clk);
        mon.clkin = v;
        model_step(cyc + 1, v);
    endtask

    task automatic pulse(int h, int l);
        for (int i = 0; i < h; i++) drive(1'b1);
        for (int i = 0; i < l; i++) drive(1'b0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_period"}, int'(mon.period), 0);
        chk({tag, "_high_time"}, int'(mon.high_time), 0);
        chk({tag, "_meas_valid"}, int'(mon.meas_valid), 0);
        chk({tag, "_locked"}, int'(mon.locked), 0);
        chk({tag, "_err"}, int'(mon.err), 0);
        chk({tag, "_err_cnt"}, int'(mon.err_cnt), 0);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        rst       = 1'b1;
        mon.clkin = 1'($urandom_range(0, 1));
        while (exp_q.size() > 0 && exp_q[$].t >= cyc + 1) void'(exp_q.pop_back());
        model_reset();
        @(negedge clk);
        check_zero(tag);
        mon.clkin = 1'($urandom_range(0, 1));
        @(negedge clk);
        rst       = 1'b0;
        mon.clkin = 1'b0;
        model_step(cyc + 1, 1'b0);
    endtask

    // monitor: compare on every DUT event; flag expected events whose time has passed
    always @(negedge clk) begin
        if (!rst_seen) begin
            while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                chk("missed_event_time", cyc, exp_q[0].t);
                void'(exp_q.pop_front());
            end
            if (mon.meas_valid || mon.err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("event_time", cyc, e.t);
                    chk("meas_valid", int'(mon.meas_valid), int'(e.mv));
                    chk("err", int'(mon.err), int'(e.er));
                    if (e.mv) begin
                        chk("period", int'(mon.period), e.per);
                        chk("high_time", int'(mon.high_time), e.hi);
                    end
                    chk("locked", int'(mon.locked), int'(e.lk));
                    chk("err_cnt", int'(mon.err_cnt), e.ec);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int h;
        rst       = 1'b1;
        rst_seen  = 1'b1;
        mon.clkin = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset("por");

        // ideal divide-by-5, then divide-by-4 after lock
        repeat (8) pulse(3, 2);
        @(negedge clk);
        chk("locked_after_ideal", int'(mon.locked), 1);
        model_step(cyc + 1, mon.clkin);
        repeat (4) pulse(2, 2);

        // duty error from reset
        do_reset("rst_duty");
        repeat (5) pulse(1, 4);
        chk("duty_never_locked", int'(mon.locked), 0);

        // lock, stuck low (single timeout), then recover
        repeat (6) pulse(3, 2);
        repeat (25) drive(1'b0);
        repeat (6) pulse(3, 2);

        // reset mid-measurement while locked
        pulse(3, 0);
        drive(1'b0);
        do_reset("rst_mid");
        repeat (4) pulse(3, 2);

        // continuous divide-by-4: err_cnt saturates and err keeps pulsing
        repeat (22) pulse(2, 2);
        chk("err_cnt_saturated", int'(mon.err_cnt), ECMAX);

        // randomized mix of good, malformed and stuck periods
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 9));
            if (k < 5) begin
                h = int'($urandom_range(2, 3));
                pulse(h, DIV - h);
            end else if (k < 8) begin
                pulse(int'($urandom_range(1, 5)), int'($urandom_range(1, 6)));
            end else begin
                pulse(int'($urandom_range(1, 3)), int'($urandom_range(9, 14)));
            end
        end

        repeat (30) drive(1'b0);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_locked", int'(mon.locked), int'(m_lck));
        chk("final_err_cnt", int'(mon.err_cnt), m_ec);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
